// File: rtl/dfb_spi_pkg.sv
// dfb_spi_pkg
// Shared definitions for the DFB1 SPI target register port: transfer state
// encoding, command byte layout and register-file geometry.
`timescale 1ns/1ps
package dfb_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR,
    RD
  } state_t;

  localparam int          CMD_READ_BIT = 7;      // command bit 7: 1 = read, 0 = write
  localparam int          ADDR_W       = 3;      // command bits [2:0]: start address
  localparam int          NREGS        = 8;
  localparam logic [7:0]  DEFAULT_ID   = 8'hDF;  // read-only contents of register 0

endpackage

// File: rtl/dfb_sync_edge.sv
// dfb_sync_edge
// Multi-flop synchroniser for an asynchronous pin, followed by one history
// flop that turns level changes into single-cycle rise/fall pulses.
//
// Ports:
//   clk   in   sampling clock
//   rst   in   asynchronous, active-high reset
//   d     in   asynchronous pin
//   rise  out  one-cycle pulse, synchronised 0->1 transition
//   fall  out  one-cycle pulse, synchronised 1->0 transition
//
// The chain and history flop reset to 0. For CS_N this means "assume
// selected" out of reset, so a transfer already under way at reset release
// produces no fall, and the first synchronised high shows up as a rise.
`timescale 1ns/1ps
module dfb_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  // NOTE: non-blocking assignments so every flop samples the value its
  // neighbour held before this edge; blocking would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      hist  <= chain[STAGES-1];
    end
  end

  assign rise =  chain[STAGES-1] & ~hist;
  assign fall = ~chain[STAGES-1] &  hist;

endmodule

// File: rtl/dfb_spi_target.sv
// dfb_spi_target
// SPI mode-0 target giving an external controller access to an 8x8 register
// file (register 0 is the read-only ID) plus a status byte that is returned
// during the command byte. Every pin is oversampled in the CLKOSC domain.
//
// Ports:
//   CLKOSC       in   system clock
//   RST          in   asynchronous, active-high reset
//   SPI_SCK      in   SPI clock (CPOL=0, CPHA=0)
//   SPI_MOSI     in   controller-out data, MSB first
//   SPI_CS_N     in   chip select, active-low
//   SPI_MISO     out  target-out data (1 when deselected)
//   SPI_MISO_OE  out  MISO driver enable, high while selected
//   STATUS       in   status byte, captured at CS_N fall
//   REGS         out  registers 7..1 in [63:8], ID_VALUE in [7:0]
//   WR_STB       out  one-cycle pulse per committed write
//   WR_ADDR      out  address of the committed write
//   WR_DATA      out  data of the committed write
//   BUSY         out  high while a transfer is in progress
//   IRQ_N        out  doorbell interrupt, only when SPI_TARGET_IRQ_EN is
//                     defined: set low by a write to register 7, released
//                     when a read loads register 7
`timescale 1ns/1ps
module dfb_spi_target
  import dfb_spi_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = DEFAULT_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLKOSC,
  input  logic        RST,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  input  logic        SPI_CS_N,
  output logic        SPI_MISO,
  output logic        SPI_MISO_OE,
  input  logic [7:0]  STATUS,
  output logic [63:0] REGS,
  output logic        WR_STB,
  output logic [2:0]  WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic        BUSY
`ifdef SPI_TARGET_IRQ_EN
  ,
  output logic        IRQ_N
`endif
);

  state_t              state, next_state;
  logic                sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                mosi_s;
  logic                armed;
  logic [2:0]          bit_cnt;     // counts SCK rises within the current byte
  logic [ADDR_W-1:0]   addr;
  logic [6:0]          shift_in;
  logic [7:0]          shift_out;
  logic [7:0]          regs [NREGS];
  logic [7:0]          rx_byte;
  logic [7:0]          rd_byte;
  logic                start, byte_rise, commit, rd_load;

  dfb_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk (CLKOSC), .rst (RST), .d (SPI_SCK), .rise (sck_rise), .fall (sck_fall)
  );

  dfb_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk (CLKOSC), .rst (RST), .d (SPI_CS_N), .rise (cs_rise), .fall (cs_fall)
  );

  // MOSI gets the same depth as SCK so the sampled bit lines up with the
  // detected rise.
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign rx_byte   = {shift_in, mosi_s};
  assign rd_byte   = (addr == '0) ? ID_VALUE : regs[addr];
  assign start     = (state == IDLE) && cs_fall && armed;
  // A CS_N rise in the same cycle as an SCK edge cancels the edge.
  assign byte_rise = sck_rise && !cs_rise && (bit_cnt == 3'd7);
  assign commit    = (state == WR) && byte_rise;
  // bit_cnt wraps to 0 on the 8th rise, so a fall seen at 0 is the byte boundary.
  assign rd_load   = (state == RD) && sck_fall && !cs_rise && (bit_cnt == 3'd0);

  // State register
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  // NOTE: next_state gets its default before any branch so every path
  // assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    if (cs_rise) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = CMD;
        CMD:     if (byte_rise) next_state = rx_byte[CMD_READ_BIT] ? RD : WR;
        default: ;
      endcase
    end
  end

  // Output logic: MISO idles high and is only driven while selected.
  always_comb begin
    BUSY        = (state != IDLE);
    SPI_MISO_OE = (state != IDLE);
    SPI_MISO    = (state != IDLE) ? shift_out[7] : 1'b1;
  end

  // Datapath: shifters, address pointer, register file, write strobe
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      armed     <= 1'b0;
      bit_cnt   <= '0;
      addr      <= '0;
      shift_in  <= '0;
      shift_out <= 8'hFF;
      WR_STB    <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
      // NOTE: the register file is reset explicitly because its contents are
      // architecturally visible on REGS and must read 0 after reset.
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      WR_STB <= 1'b0;
      if (cs_rise) begin
        // The sync chain resets low, so the first high CS_N appears as a rise.
        armed   <= 1'b1;
        bit_cnt <= '0;
      end else begin
        if (start) begin
          shift_out <= STATUS;
          bit_cnt   <= '0;
        end
        if (state != IDLE && sck_rise) begin
          shift_in <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (state == CMD && byte_rise) addr <= rx_byte[ADDR_W-1:0];
        if (commit) begin
          // Register 0 is the ID: the write is dropped but the pointer moves on.
          if (addr != '0) begin
            regs[addr] <= rx_byte;
            WR_STB     <= 1'b1;
            WR_ADDR    <= addr;
            WR_DATA    <= rx_byte;
          end
          addr <= addr + ADDR_W'(1);
        end
        if (state != IDLE && sck_fall) begin
          if (rd_load) begin
            shift_out <= rd_byte;
            addr      <= addr + ADDR_W'(1);
          end else begin
            // Shifting in ones makes the write phase return 8'hFF.
            shift_out <= {shift_out[6:0], 1'b1};
          end
        end
      end
    end
  end

  always_comb begin
    REGS      = '0;
    REGS[7:0] = ID_VALUE;
    for (int r = 1; r < NREGS; r++) REGS[8*r +: 8] = regs[r];
  end

`ifdef SPI_TARGET_IRQ_EN
  // Doorbell: set has priority over clear.
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST)                                          IRQ_N <= 1'b1;
    else if (commit  && addr == ADDR_W'(NREGS - 1))   IRQ_N <= 1'b0;
    else if (rd_load && addr == ADDR_W'(NREGS - 1))   IRQ_N <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dfb_spi_target.sv
`timescale 1ns/1ps
module tb_dfb_spi_target;

  logic        CLKOSC = 1'b0;
  logic        RST;
  logic        SPI_SCK, SPI_MOSI, SPI_CS_N;
  logic        SPI_MISO, SPI_MISO_OE;
  logic [7:0]  STATUS;
  logic [63:0] REGS;
  logic        WR_STB;
  logic [2:0]  WR_ADDR;
  logic [7:0]  WR_DATA;
  logic        BUSY;
`ifdef SPI_TARGET_IRQ_EN
  logic        IRQ_N;
`endif

  dfb_spi_target dut (
    .CLKOSC      (CLKOSC),
    .RST         (RST),
    .SPI_SCK     (SPI_SCK),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_CS_N    (SPI_CS_N),
    .SPI_MISO    (SPI_MISO),
    .SPI_MISO_OE (SPI_MISO_OE),
    .STATUS      (STATUS),
    .REGS        (REGS),
    .WR_STB      (WR_STB),
    .WR_ADDR     (WR_ADDR),
    .WR_DATA     (WR_DATA),
    .BUSY        (BUSY)
`ifdef SPI_TARGET_IRQ_EN
    ,
    .IRQ_N       (IRQ_N)
`endif
  );

  always #10 CLKOSC = ~CLKOSC;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard queues: expected MISO bytes and expected {addr, data} commits
  logic [7:0]  exp_rx[$];
  logic [10:0] exp_wr[$];

  // Reference model of the target's architectural state
  logic [7:0]  model_regs [8];
  logic        model_irq_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [2:0] a);
    return (a == 3'd0) ? 8'hDF : model_regs[a];
  endfunction

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    v[7:0] = 8'hDF;
    for (int r = 1; r < 8; r++) v[8*r +: 8] = model_regs[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) model_regs[r] = 8'h00;
    model_irq_n = 1'b1;
  endtask

  // MISO monitor: assembles bytes at each SCK rise while selected
  logic [7:0] rx_sh;
  int         rx_cnt = 0;
  always @(posedge SPI_SCK or posedge SPI_CS_N or posedge RST) begin : mon_miso
    logic [7:0] e;
    if (SPI_CS_N || RST) begin
      rx_cnt = 0;
    end else begin
      rx_sh = {rx_sh[6:0], SPI_MISO};
      rx_cnt++;
      if (rx_cnt == 8) begin
        rx_cnt = 0;
        if (exp_rx.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL miso_byte_unexpected: got %h, required no byte", rx_sh);
        end else begin
          e = exp_rx.pop_front();
          check("miso_byte", {56'h0, rx_sh}, {56'h0, e});
        end
      end
    end
  end

  // Write-strobe monitor
  always @(negedge CLKOSC) begin : mon_wr
    logic [10:0] e;
    if (WR_STB === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_stb_unexpected: got addr %0d data %h, required no strobe", WR_ADDR, WR_DATA);
      end else begin
        e = exp_wr.pop_front();
        check("wr_commit", {53'h0, WR_ADDR, WR_DATA}, {53'h0, e});
      end
    end
  end

  task automatic sck_bits(input logic [7:0] b, input int nb);
    for (int i = 0; i < nb; i++) begin
      SPI_MOSI = b[7-i];
      #80 SPI_SCK = 1'b1;
      #80 SPI_SCK = 1'b0;
    end
  endtask

  task automatic idle_checks();
    check("regs",      REGS, model_vec());
    check("busy_idle", {63'h0, BUSY}, 64'h0);
    check("oe_idle",   {63'h0, SPI_MISO_OE}, 64'h0);
    check("miso_idle", {63'h0, SPI_MISO}, 64'h1);
`ifdef SPI_TARGET_IRQ_EN
    check("irq_n",     {63'h0, IRQ_N}, {63'h0, model_irq_n});
`endif
  endtask

  // One complete transfer: command byte plus n data bytes (byte i in data[8*i+:8])
  task automatic xfer(input logic [7:0] cmd, input int n, input logic [23:0] data);
    logic [2:0] a;
    logic [7:0] b;
    exp_rx.push_back(STATUS);
    if (cmd[7]) begin
      for (int i = 0; i < n; i++) begin
        a = cmd[2:0] + 3'(i);
        exp_rx.push_back(model_rd(a));
      end
      // Loads happen at every byte boundary, including the last data byte's.
      for (int i = 0; i <= n; i++) begin
        a = cmd[2:0] + 3'(i);
        if (a == 3'd7) model_irq_n = 1'b1;
      end
    end else begin
      for (int i = 0; i < n; i++) begin
        a = cmd[2:0] + 3'(i);
        b = data[8*i +: 8];
        exp_rx.push_back(8'hFF);
        if (a != 3'd0) begin
          model_regs[a] = b;
          exp_wr.push_back({a, b});
          if (a == 3'd7) model_irq_n = 1'b0;
        end
      end
    end
    SPI_CS_N = 1'b0;
    #100;
    check("busy_sel",     {63'h0, BUSY}, 64'h1);
    check("oe_sel",       {63'h0, SPI_MISO_OE}, 64'h1);
    check("miso_status7", {63'h0, SPI_MISO}, {63'h0, STATUS[7]});
    sck_bits(cmd, 8);
    for (int i = 0; i < n; i++) sck_bits(data[8*i +: 8], 8);
    #100 SPI_CS_N = 1'b1;
    #200;
    idle_checks();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    RST      = 1'b1;
    SPI_SCK  = 1'b0;
    SPI_MOSI = 1'b0;
    SPI_CS_N = 1'b1;
    STATUS   = 8'h3C;
    model_reset();
    repeat (3) @(negedge CLKOSC);
    check("rst_regs",    REGS, 64'h00000000_000000DF);
    check("rst_miso",    {63'h0, SPI_MISO}, 64'h1);
    check("rst_oe",      {63'h0, SPI_MISO_OE}, 64'h0);
    check("rst_wr_stb",  {63'h0, WR_STB}, 64'h0);
    check("rst_wr_addr", {61'h0, WR_ADDR}, 64'h0);
    check("rst_wr_data", {56'h0, WR_DATA}, 64'h0);
    check("rst_busy",    {63'h0, BUSY}, 64'h0);
`ifdef SPI_TARGET_IRQ_EN
    check("rst_irq_n",   {63'h0, IRQ_N}, 64'h1);
`endif
    RST = 1'b0;
    repeat (6) @(negedge CLKOSC);

    // Write burst from address 3, then read it back with a live status byte
    xfer(8'h03, 2, 24'h00_C3_5A);
    check("reg3", {56'h0, REGS[31:24]}, 64'h5A);
    check("reg4", {56'h0, REGS[39:32]}, 64'hC3);
    STATUS = 8'h81;
    xfer(8'h83, 2, 24'h0);

    // Write at 7 wraps to the read-only ID slot; read the ID
    xfer(8'h07, 2, 24'h00_22_11);
    xfer(8'h80, 1, 24'h0);

    // Doorbell: write reg6 leaves it, read from 7 releases it
    xfer(8'h06, 1, 24'h00_00_77);
    xfer(8'h87, 1, 24'h0);

    // Aborted data byte to reg2: 5 bits, then deselect
    STATUS = 8'h42;
    exp_rx.push_back(STATUS);
    SPI_CS_N = 1'b0;
    #100;
    sck_bits(8'h02, 8);
    sck_bits(8'hA5, 5);
    #100 SPI_CS_N = 1'b1;
    #200;
    idle_checks();

    // Reset mid-read, release with CS_N still low: activity must be ignored
    STATUS = 8'hE7;
    exp_rx.push_back(STATUS);
    SPI_CS_N = 1'b0;
    #100;
    sck_bits(8'h81, 8);
    sck_bits(8'h00, 3);
    RST = 1'b1;
    model_reset();
    #60 RST = 1'b0;
    #100;
    check("oe_after_rst",   {63'h0, SPI_MISO_OE}, 64'h0);
    check("busy_after_rst", {63'h0, BUSY}, 64'h0);
    exp_rx.push_back(8'hFF);
    for (int i = 0; i < 8; i++) begin
      SPI_MOSI = 1'($urandom_range(0, 1));
      #80 SPI_SCK = 1'b1;
      check("oe_ignored", {63'h0, SPI_MISO_OE}, 64'h0);
      #80 SPI_SCK = 1'b0;
    end
    #100 SPI_CS_N = 1'b1;
    #200;
    idle_checks();
    STATUS = 8'h5E;
    xfer(8'h81, 1, 24'h0);

    // Randomized transfers against the model
    for (int t = 0; t < 25; t++) begin
      STATUS = 8'($urandom);
      xfer(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)), 24'($urandom));
    end

    repeat (10) @(negedge CLKOSC);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'h0);
    check("rx_queue_empty", 64'(exp_rx.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dfb_spi_target.md
Name: dfb_spi_target

Overview:
- SPI mode-0 target (slave) that is the far end of the DFB1 SPI master register port.
- Gives an external controller, or a second DFB1 on the header pins, access to a small 8x8 register file plus a live status byte.
- SCK, MOSI and CS_N are asynchronous. They are oversampled and edge-detected in the CLKOSC domain.
- All logic is clocked by CLKOSC.

Parameters:
- ID_VALUE, 8'hDF, read-only contents of register 0.
- SYNC_STAGES, 2, synchroniser depth on SCK, MOSI and CS_N (minimum 2).

Ports:
- CLKOSC  in  1  system clock, 50 MHz nominal.
- RST  in  1  reset, asynchronous, active-high.
- SPI_SCK  in  1  SPI clock; CPOL=0, CPHA=0.
- SPI_MOSI  in  1  master-out data, MSB first.
- SPI_CS_N  in  1  chip select, active-low.
- SPI_MISO  out  1  target-out data.
- SPI_MISO_OE  out  1  MISO driver enable; high only while selected.
- STATUS  in  8  status byte, captured at CS_N fall.
- REGS  out  64  registers 7..1 in bits [63:8]; bits [7:0] = ID_VALUE.
- WR_STB  out  1  one-CLKOSC pulse per committed write.
- WR_ADDR  out  3  address of the committed write.
- WR_DATA  out  8  data of the committed write.
- BUSY  out  1  high while in any state other than IDLE.

Behaviour:
- Reset values:
  - SPI_MISO=1, SPI_MISO_OE=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, BUSY=0.
  - Registers 1..7 = 8'h00.
  - State IDLE, bit counter 0, armed=0.
- Synchronisation and edge timing:
  - Inputs pass through SYNC_STAGES flops, then one history flop for edge detection.
  - Supported SCK frequency is at most CLKOSC/6.
  - Internal reaction occurs SYNC_STAGES+1 CLKOSC cycles after a pin edge.
- Arming:
  - After reset, the block ignores all activity until a synchronised CS_N high is seen (armed=1).
  - A transfer already in progress when reset releases is therefore ignored entirely.
- Protocol:
  - Byte 0 is the command: bit7 R/nW, bits[6:3] ignored, bits[2:0] start address.
  - Subsequent bytes are data at address A, A+1, and so on. The address increments modulo 8 (7 wraps to 0).
- State machine:
  - IDLE:
    - On CS_N fall while armed: capture STATUS into the shift-out register, assert OE, drive MISO = STATUS[7], clear the bit counter, go to CMD.
  - CMD:
    - SCK rise: shift MOSI in.
    - SCK fall: shift the next STATUS bit out.
    - After the 8th rise, latch the address and direction. Go to RD if bit7=1, otherwise WR.
    - For RD, load reg[A] into the shift-out register and present its bit7 on the 8th SCK fall.
  - WR:
    - After each 8th rise, commit the byte to reg[A] and pulse WR_STB for 1 cycle with WR_ADDR=A and WR_DATA=byte. Then A <= A+1.
    - Writes to address 0 are discarded with no WR_STB, but the address still increments.
    - MISO shifts 8'hFF while in WR.
  - RD:
    - On each byte boundary (8th fall), load reg[A] with A incremented.
    - Data read reflects register contents at that boundary.
- CS_N rise in any state: return to IDLE within 1 cycle of detection, OE=0, MISO=1. Any partial byte is discarded and never committed.
- Same-cycle SCK edge and CS_N rise: CS_N wins; the edge is ignored.
- WR_STB has priority over nothing; it cannot collide because only one commit happens per byte.

Optional Feature:
- Macro: SPI_TARGET_IRQ_EN.
- When defined:
  - Adds output IRQ_N (1 bit, reset 1).
  - IRQ_N goes 0 on the cycle after a committed write to register 7 (doorbell).
  - IRQ_N returns to 1 when an RD transfer loads register 7 into the shift-out register.
  - If a set and a clear occur in the same cycle, the set wins.
- When undefined: no IRQ_N port and no associated logic.

Decomposition:
- Shared package dfb_spi_pkg holds:
  - state enum {IDLE, CMD, WR, RD};
  - CMD_READ_BIT=7;
  - ADDR_W=3;
  - NREGS=8;
  - default ID 8'hDF.
- One sub-module, dfb_sync_edge: an N-stage synchroniser with rise/fall pulse outputs, instantiated for SCK and CS_N. MOSI uses the sync chain only.

Test Plan:
- Reset, then: write cmd 8'h03, data 8'h5A, 8'hC3 -> WR_STB pulses with (3,5A) then (4,C3); REGS[31:24]=5A, REGS[39:32]=C3.
- STATUS=8'h81, read cmd 8'h83 clocking 2 bytes -> MISO returns 8'h81, then 8'h5A, then 8'hC3.
- Write cmd 8'h07, data 11,22 -> reg7=11, reg0 discarded with no strobe. Read cmd 8'h80 -> 8'hDF.
- CS_N rises after 5 bits of a data byte to reg2 -> no WR_STB, reg2 unchanged, OE=0, BUSY=0.
- Assert RST mid-read, release while CS_N still low -> MISO_OE stays 0 until CS_N high then low. A following read cmd 8'h81 returns 8'h00.
- With SPI_TARGET_IRQ_EN: write reg7 -> IRQ_N=0. Read from address 7 -> IRQ_N=1. Write reg6 -> IRQ_N unchanged.
